regfile_wport_arb: RTL and testbench
====================================

Name: regfile_wport_arb

Overview:
Arbitrates the single regfile write port between the in-order pipeline writeback (requester 0) and the iterative mul/div unit (requester 1), using val/rdy handshakes with a bounded-starvation priority rule. It drives the regfile write port from registered outputs. It also keeps a 32-entry pending-write scoreboard, which issue logic queries to stall reads of registers whose writes have not yet committed. The regfile does not bypass write data to read data, so the scoreboard is the hazard source of truth.

Parameters:
XLEN, 32, data width of write data
STARVE_LIMIT, 4, consecutive stalled cycles of requester 1 after which it wins once over requester 0 (must be >= 1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req0_val  input  1  writeback write request valid
req0_rdy  output  1  writeback request accepted this cycle
req0_addr  input  5  writeback destination register
req0_data  input  XLEN  writeback data
req1_val  input  1  mul/div write request valid
req1_rdy  output  1  mul/div request accepted this cycle
req1_addr  input  5  mul/div destination register
req1_data  input  XLEN  mul/div data
wen  output  1  regfile write enable (registered)
waddr  output  5  regfile write address (registered)
wdata  output  XLEN  regfile write data (registered)
sb_set_val  input  1  issue marks a destination as pending
sb_set_addr  input  5  register to mark pending
flush  input  1  clear all pending bits
q0_addr  input  5  scoreboard query address 0
q0_busy  output  1  q0_addr has a pending write
q1_addr  input  5  scoreboard query address 1
q1_busy  output  1  q1_addr has a pending write
pending  output  32  full scoreboard vector

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted: wen=0, waddr=0, wdata=0, pending=0, starve counter=0, req0_rdy=0, req1_rdy=0.
- A transfer occurs when reqN_val and reqN_rdy are both high in the same cycle. The rdy signals are combinational from the val inputs and the starve counter only, never from the data or address inputs.
- Grant rule:
  - Only one requester valid: that requester gets rdy=1.
  - Both valid: requester 0 wins, unless the starve counter == STARVE_LIMIT, in which case requester 1 wins.
  - Never more than one rdy high in a cycle.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle in which req1_val=1 and req1_rdy=0.
  - Clears to 0 on a requester 1 transfer or whenever req1_val=0.
- Write latency: a transfer in cycle N produces wen=1 with the captured addr/data during cycle N+1; the regfile commits at the end of N+1. With no transfer in N, wen=0 in N+1; waddr/wdata hold their previous values.
- x0 writes: the request is still accepted (rdy follows the grant rule), but wen stays 0 in N+1 and the scoreboard is untouched.
- Back-to-back transfers sustain one write per cycle. Commit order equals transfer order, so the same register written in consecutive cycles ends with the later value.
- Scoreboard, updated each clock edge:
  - Clear: bit waddr clears when wen=1.
  - Set: bit sb_set_addr sets when sb_set_val=1 and sb_set_addr!=0.
  - Set and clear on the same address in the same cycle: set wins (a new producer is in flight).
  - flush=1 clears all bits and overrides set/clear in that cycle.
  - Setting an already-set bit leaves it set.
  - Bit 0 is always 0.
- q0_busy = pending[q0_addr], q1_busy = pending[q1_addr]. Both are combinational on the current pending value, with no forwarding of this cycle's set or clear.
- Reset asserted mid-operation: any accepted-but-uncommitted write is dropped (wen forced to 0) and the scoreboard is cleared.

Test Plan:
- Single write: req0 valid with addr=5, data=0xDEADBEEF in cycle 3 -> req0_rdy=1 in cycle 3; wen=1, waddr=5, wdata=0xDEADBEEF in cycle 4; wen=0 in cycle 5.
- Contention: both valid continuously, STARVE_LIMIT=4 -> req0 granted for 4 cycles, req1 granted in the 5th, counter returns to 0, pattern repeats.
- x0: req1 with addr=0, data=0x1234 -> req1_rdy=1; wen stays 0; pending unchanged.
- Scoreboard: sb_set addr=7 in cycle 1 -> q0_busy=1 for q0_addr=7 from cycle 2. req0 write to 7 in cycle 4 -> wen in cycle 5, bit 7 clear from cycle 6. Repeat with sb_set addr=7 in cycle 5 -> bit stays 1.
- Flush/reset: pending=0x0000_00F0 with flush=1 -> pending=0 next cycle. Assert reset asynchronously mid-cycle while wen=1 -> wen, pending and both rdy drop immediately, with no clock edge needed.

Source files
------------

// File: rtl/regfile_wport_arb.sv
// Regfile write-port arbiter: writeback (req0) vs mul/div (req1) with bounded
// starvation of req1, registered write port, and a 32-entry pending-write scoreboard.
module regfile_wport_arb #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_val,
  output logic            req0_rdy,
  input  logic [4:0]      req0_addr,
  input  logic [XLEN-1:0] req0_data,
  input  logic            req1_val,
  output logic            req1_rdy,
  input  logic [4:0]      req1_addr,
  input  logic [XLEN-1:0] req1_data,
  output logic            wen,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata,
  input  logic            sb_set_val,
  input  logic [4:0]      sb_set_addr,
  input  logic            flush,
  input  logic [4:0]      q0_addr,
  output logic            q0_busy,
  input  logic [4:0]      q1_addr,
  output logic            q1_busy,
  output logic [31:0]     pending
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_REQ0,
    GNT_REQ1
  } grant_e;

  grant_e          grant;
  logic            starve_hit;
  logic [SW-1:0]   starve_q, starve_d;
  logic            wen_q, wen_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [31:0]     pending_q, pending_d;

  assign starve_hit = (starve_q == SW'(STARVE_LIMIT));

  // Grant depends only on the valids and the starve counter, so rdy never
  // combinationally follows address or data.
  always_comb begin
    grant = GNT_NONE;
    if (req0_val && req1_val) grant = starve_hit ? GNT_REQ1 : GNT_REQ0;
    else if (req0_val)        grant = GNT_REQ0;
    else if (req1_val)        grant = GNT_REQ1;
    if (reset)                grant = GNT_NONE;
  end

  assign req0_rdy = (grant == GNT_REQ0);
  assign req1_rdy = (grant == GNT_REQ1);

  always_comb begin
    starve_d = starve_q;
    if (!req1_val || req1_rdy) starve_d = '0;
    else if (!starve_hit)      starve_d = starve_q + SW'(1);
  end

  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (grant)
      GNT_REQ0: if (req0_addr != 5'd0) begin
        wen_d   = 1'b1;
        waddr_d = req0_addr;
        wdata_d = req0_data;
      end
      GNT_REQ1: if (req1_addr != 5'd0) begin
        wen_d   = 1'b1;
        waddr_d = req1_addr;
        wdata_d = req1_data;
      end
      default: ;
    endcase
  end

  // Set is applied after clear so a new producer for the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (wen_q) pending_d[waddr_q] = 1'b0;
    if (sb_set_val && (sb_set_addr != 5'd0)) pending_d[sb_set_addr] = 1'b1;
    if (flush) pending_d = '0;
    pending_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the scoreboard is a flop vector and is reset like any other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q  <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      starve_q  <= starve_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

  assign wen     = wen_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign pending = pending_q;
  assign q0_busy = pending_q[q0_addr];
  assign q1_busy = pending_q[q1_addr];

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Self-checking bench for regfile_wport_arb: directed steps plus a randomized
// phase, all compared against a rule-level reference model.
module tb_regfile_wport_arb;

  localparam int XLEN         = 32;
  localparam int STARVE_LIMIT = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            req0_val, req1_val;
  logic            req0_rdy, req1_rdy;
  logic [4:0]      req0_addr, req1_addr;
  logic [XLEN-1:0] req0_data, req1_data;
  logic            wen;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wdata;
  logic            sb_set_val;
  logic [4:0]      sb_set_addr;
  logic            flush;
  logic [4:0]      q0_addr, q1_addr;
  logic            q0_busy, q1_busy;
  logic [31:0]     pending;

  regfile_wport_arb #(.XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_addr(req1_addr), .req1_data(req1_data),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .sb_set_val(sb_set_val), .sb_set_addr(sb_set_addr), .flush(flush),
    .q0_addr(q0_addr), .q0_busy(q0_busy), .q1_addr(q1_addr), .q1_busy(q1_busy),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int r1_grants;

  // Reference model state
  int              m_starve;
  logic [31:0]     m_pend;
  logic            m_wen;
  logic [4:0]      m_waddr;
  logic [XLEN-1:0] m_wdata;
  logic [XLEN-1:0] model_rf [32] = '{default: '0};
  logic [XLEN-1:0] tb_rf    [32] = '{default: '0};

  // Register file as actually written through the DUT's port
  always @(posedge clk) if (wen) tb_rf[waddr] <= wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req0_val = 0; req1_val = 0; sb_set_val = 0; flush = 0;
  endtask

  task automatic model_reset();
    m_starve = 0; m_pend = '0; m_wen = 0; m_waddr = '0; m_wdata = '0;
  endtask

  // One clock cycle with the inputs already driven: check rdy/busy before the
  // edge, advance the model at the edge, check registered outputs after it.
  task automatic step();
    logic e0, e1;
    #1;
    e0 = 0; e1 = 0;
    if (req0_val && req1_val) begin
      if (m_starve == STARVE_LIMIT) e1 = 1; else e0 = 1;
    end else if (req0_val) e0 = 1;
    else if (req1_val)     e1 = 1;
    chk("req0_rdy", 64'(req0_rdy), 64'(e0));
    chk("req1_rdy", 64'(req1_rdy), 64'(e1));
    chk("q0_busy", 64'(q0_busy), 64'(m_pend[q0_addr]));
    chk("q1_busy", 64'(q1_busy), 64'(m_pend[q1_addr]));
    if (req1_rdy) r1_grants++;
    @(posedge clk);
    if (m_wen) model_rf[m_waddr] = m_wdata;
    if (flush) m_pend = '0;
    else begin
      if (m_wen) m_pend[m_waddr] = 1'b0;
      if (sb_set_val && sb_set_addr != 0) m_pend[sb_set_addr] = 1'b1;
    end
    if (!req1_val || e1) m_starve = 0;
    else if (m_starve < STARVE_LIMIT) m_starve++;
    m_wen = 0;
    if (e0 && req0_addr != 0) begin m_wen = 1; m_waddr = req0_addr; m_wdata = req0_data; end
    if (e1 && req1_addr != 0) begin m_wen = 1; m_waddr = req1_addr; m_wdata = req1_data; end
    #1;
    chk("wen", 64'(wen), 64'(m_wen));
    if (m_wen) begin
      chk("waddr", 64'(waddr), 64'(m_waddr));
      chk("wdata", 64'(wdata), 64'(m_wdata));
    end
    chk("pending", 64'(pending), 64'(m_pend));
  endtask

  initial begin
    reset = 1;
    idle();
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    sb_set_addr = '0; q0_addr = '0; q1_addr = '0;
    model_reset();
    r1_grants = 0;

    // Reset state: outputs cleared, no grant even with valids high
    req0_val = 1; req1_val = 1;
    #3;
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_req0_rdy", 64'(req0_rdy), 64'd0);
    chk("rst_req1_rdy", 64'(req1_rdy), 64'd0);
    idle();
    @(posedge clk); #1;
    reset = 0;

    // Single write, then idle
    req0_val = 1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    step();
    chk("single_wdata", 64'(wdata), 64'hDEADBEEF);
    idle();
    step();

    // Contention: req1 wins once every STARVE_LIMIT+1 cycles
    r1_grants = 0;
    req0_val = 1; req1_val = 1;
    for (int i = 0; i < 2 * (STARVE_LIMIT + 1); i++) begin
      req0_addr = 5'(i + 1);  req0_data = 32'h1000 + i;
      req1_addr = 5'(i + 16); req1_data = 32'h2000 + i;
      step();
    end
    chk("contention_r1_grants", 64'(r1_grants), 64'd2);
    idle();
    step();

    // x0 write from req1: accepted, no write, scoreboard unchanged
    req1_val = 1; req1_addr = 5'd0; req1_data = 32'h1234;
    step();
    idle();
    step();

    // Scoreboard set, query, clear by write; then set-wins on collision
    sb_set_val = 1; sb_set_addr = 5'd7; q0_addr = 5'd7; q1_addr = 5'd0;
    step();
    sb_set_val = 0;
    step();
    chk("sb_busy7", 64'(q0_busy), 64'd1);
    req0_val = 1; req0_addr = 5'd7; req0_data = 32'hA5A5_0007;
    step();
    req0_val = 0;
    step();
    step();
    chk("sb_cleared7", 64'(q0_busy), 64'd0);
    req0_val = 1;
    step();
    req0_val = 0; sb_set_val = 1; sb_set_addr = 5'd7;
    step();
    sb_set_val = 0;
    step();
    chk("sb_setwins7", 64'(q0_busy), 64'd1);

    // sb_set on x0 is ignored
    sb_set_val = 1; sb_set_addr = 5'd0; q1_addr = 5'd0;
    step();

    // Flush from pending = 0xF0
    for (int a = 4; a < 8; a++) begin
      sb_set_addr = 5'(a);
      step();
    end
    sb_set_val = 0;
    chk("flush_pre", 64'(pending), 64'h0000_00F0);
    flush = 1; sb_set_val = 1; sb_set_addr = 5'd9;
    step();
    flush = 0; sb_set_val = 0;
    chk("flush_post", 64'(pending), 64'd0);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      req0_val    = ($urandom_range(0, 3) != 0);
      req1_val    = ($urandom_range(0, 2) != 0);
      req0_addr   = 5'($urandom_range(0, 31));
      req1_addr   = 5'($urandom_range(0, 31));
      req0_data   = $urandom;
      req1_data   = $urandom;
      sb_set_val  = ($urandom_range(0, 1) != 0);
      sb_set_addr = 5'($urandom_range(0, 31));
      flush       = ($urandom_range(0, 31) == 0);
      q0_addr     = 5'($urandom_range(0, 31));
      q1_addr     = 5'($urandom_range(0, 31));
      step();
    end
    idle();
    step();

    // Async reset mid-cycle while wen=1: everything drops with no clock edge
    sb_set_val = 1; sb_set_addr = 5'd12;
    step();
    sb_set_val = 0;
    req0_val = 1; req0_addr = 5'd3; req0_data = 32'hCAFE_F00D;
    step();
    chk("pre_rst_wen", 64'(wen), 64'd1);
    req1_val = 1;
    #2 reset = 1;
    #1;
    chk("async_wen", 64'(wen), 64'd0);
    chk("async_pending", 64'(pending), 64'd0);
    chk("async_req0_rdy", 64'(req0_rdy), 64'd0);
    chk("async_req1_rdy", 64'(req1_rdy), 64'd0);
    model_reset();
    idle();
    #1 reset = 0;
    step();

    // Commit-order check: every register holds the last value the model committed
    step();
    for (int r = 0; r < 32; r++) chk($sformatf("rf_x%0d", r), 64'(tb_rf[r]), 64'(model_rf[r]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
